// File: rtl/writeback_sequencer_pkg.sv
// Shared types and widths for the register-file write-back path.
package writeback_sequencer_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Load-result queue: power-of-two depth, wrapping pointers, combinational head.
module wb_fifo
  import writeback_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clock,
  input  logic                         resetN,
  input  logic                         push,
  input  wb_entry_t                    push_entry,
  input  logic                         pop,
  output wb_entry_t                    head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/writeback_sequencer.sv
// Drives the register-file write port: merges ALU results with queued loads,
// guards against load starvation and tracks outstanding loads per register.
module writeback_sequencer
  import writeback_sequencer_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  aluValid,
  input  logic [REG_ADDR_W-1:0] aluRd,
  input  logic [DATA_W-1:0]     aluData,
  output logic                  holdAlu,
  input  logic                  memValid,
  input  logic [REG_ADDR_W-1:0] memRd,
  input  logic [DATA_W-1:0]     memData,
  output logic                  memReady,
  input  logic                  issueValid,
  input  logic [REG_ADDR_W-1:0] issueRd,
  output logic [REG_ADDR_W-1:0] rdOut,
  output logic [DATA_W-1:0]     writeBackData,
  output logic [NUM_REGS-1:0]   pendingMask
);

  localparam int CNT_W    = $clog2(DEPTH + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  wb_entry_t            fifo_head;
  wb_entry_t            push_entry;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic                 sel_alu;

  wb_entry_t            wb_q, wb_next;
  logic                 hold_q, hold_next;
  logic [STARVE_W-1:0]  starve_q, starve_next;
  logic [NUM_REGS-1:0]  pending_q, pending_next;

  assign push_entry = '{rd: memRd, data: memData};
  assign fifo_push  = memValid && !fifo_full;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clock      (clock),
    .resetN     (resetN),
    .push       (fifo_push),
    .push_entry (push_entry),
    .pop        (fifo_pop),
    .head       (fifo_head),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .count      (fifo_count)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wb_q      <= '0;
      hold_q    <= 1'b0;
      starve_q  <= '0;
      pending_q <= '0;
    end else begin
      wb_q      <= wb_next;
      hold_q    <= hold_next;
      starve_q  <= starve_next;
      pending_q <= pending_next;
    end
  end

  always_comb begin
    sel_alu  = aluValid && !hold_q;
    fifo_pop = !sel_alu && !fifo_empty;

    wb_next = '0;
    if (sel_alu)       wb_next = '{rd: aluRd, data: aluData};
    else if (fifo_pop) wb_next = fifo_head;
    // Writes to register 0 must leave it reading as zero.
    if (wb_next.rd == '0) wb_next.data = '0;

    if (fifo_empty || fifo_pop) starve_next = '0;
    else if (sel_alu)           starve_next = starve_q + STARVE_W'(1);
    else                        starve_next = starve_q;

    hold_next = !hold_q && (starve_next == STARVE_W'(STARVE_LIMIT));

    // Clear before set so a same-cycle reissue keeps the bit.
    pending_next = pending_q;
    if (fifo_pop) pending_next[fifo_head.rd] = 1'b0;
    if (issueValid && (issueRd != '0)) pending_next[issueRd] = 1'b1;
  end

  assign rdOut         = wb_q.rd;
  assign writeBackData = wb_q.data;
  assign holdAlu       = hold_q;
  assign memReady      = (fifo_count != CNT_W'(DEPTH));
  assign pendingMask   = pending_q;

endmodule

// File: tb/tb_writeback_sequencer.sv
// Directed bench for writeback_sequencer with hand-computed expectations.
module tb_writeback_sequencer;

  logic        clock;
  logic        resetN;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        holdAlu;
  logic        memValid;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        memReady;
  logic        issueValid;
  logic [4:0]  issueRd;
  logic [4:0]  rdOut;
  logic [31:0] writeBackData;
  logic [31:0] pendingMask;

  int n_checks = 0;
  int n_errors = 0;

  writeback_sequencer #(.DEPTH(4), .STARVE_LIMIT(3)) dut (
    .clock         (clock),
    .resetN        (resetN),
    .aluValid      (aluValid),
    .aluRd         (aluRd),
    .aluData       (aluData),
    .holdAlu       (holdAlu),
    .memValid      (memValid),
    .memRd         (memRd),
    .memData       (memData),
    .memReady      (memReady),
    .issueValid    (issueValid),
    .issueRd       (issueRd),
    .rdOut         (rdOut),
    .writeBackData (writeBackData),
    .pendingMask   (pendingMask)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starvation scenario, one row per cycle.
  logic [31:0] st_alu  [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h104, 32'h104};
  logic [4:0]  st_rd   [6] = '{5'd3, 5'd3, 5'd3, 5'd3, 5'd12, 5'd3};
  logic [31:0] st_data [6] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'hAAAA, 32'h104};
  logic        st_hold [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};

  // FIFO-full scenario, one row per cycle.
  logic        ff_av   [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  logic [31:0] ff_ad   [11] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h204, 32'h204, 0, 0, 0, 0, 0};
  logic        ff_mv   [11] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
  logic [4:0]  ff_mrd  [11] = '{5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd20, 0, 0, 0, 0, 0};
  logic [4:0]  ff_rd   [11] = '{5'd2, 5'd2, 5'd2, 5'd2, 5'd16, 5'd2, 5'd17, 5'd18, 5'd19, 5'd20, 5'd0};
  logic [31:0] ff_data [11] = '{32'h200, 32'h201, 32'h202, 32'h203, 32'hC0, 32'h204,
                                32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'h0};
  logic        ff_rdy  [11] = '{1, 1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
  logic        ff_hold [11] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};

  initial begin
    resetN = 1'b1;
    aluValid = 0; aluRd = 0; aluData = 0;
    memValid = 0; memRd = 0; memData = 0;
    issueValid = 0; issueRd = 0;
    #2 resetN = 1'b0;
    tick();
    tick();
    check_val("rst_rd",      32'(rdOut), 0);
    check_val("rst_data",    writeBackData, 0);
    check_val("rst_hold",    32'(holdAlu), 0);
    check_val("rst_pending", pendingMask, 0);
    check_val("rst_ready",   32'(memReady), 1);
    @(negedge clock);
    resetN = 1'b1;
    tick();

    // ALU write, then idle
    aluValid = 1; aluRd = 5; aluData = 32'hDEADBEEF;
    tick();
    check_val("alu_rd",   32'(rdOut), 5);
    check_val("alu_data", writeBackData, 32'hDEADBEEF);
    aluValid = 0;
    tick();
    check_val("idle_rd",   32'(rdOut), 0);
    check_val("idle_data", writeBackData, 0);

    // Load path with scoreboard
    issueValid = 1; issueRd = 9;
    tick();
    check_val("ld_pend_set", pendingMask, 32'h0000_0200);
    issueValid = 0;
    memValid = 1; memRd = 9; memData = 32'h12345678;
    tick();
    memValid = 0;
    check_val("ld_no_bypass", 32'(rdOut), 0);
    check_val("ld_pend_hold", pendingMask, 32'h0000_0200);
    tick();
    check_val("ld_rd",      32'(rdOut), 9);
    check_val("ld_data",    writeBackData, 32'h12345678);
    check_val("ld_pend_clr", pendingMask, 0);
    tick();

    // Starvation: one load queued against a continuous ALU stream
    for (int i = 0; i < 6; i++) begin
      aluValid = 1; aluRd = 3; aluData = st_alu[i];
      memValid = (i == 0); memRd = 12; memData = 32'hAAAA;
      tick();
      check_val($sformatf("st_rd%0d", i),   32'(rdOut), 32'(st_rd[i]));
      check_val($sformatf("st_data%0d", i), writeBackData, st_data[i]);
      check_val($sformatf("st_hold%0d", i), 32'(holdAlu), 32'(st_hold[i]));
    end
    aluValid = 0; memValid = 0;
    tick();

    // FIFO full under ALU saturation
    for (int i = 0; i < 11; i++) begin
      aluValid = ff_av[i]; aluRd = 2; aluData = ff_ad[i];
      memValid = ff_mv[i]; memRd = ff_mrd[i]; memData = 32'hC0 + 32'(ff_mrd[i]) - 32'd16;
      tick();
      check_val($sformatf("ff_rd%0d", i),    32'(rdOut), 32'(ff_rd[i]));
      check_val($sformatf("ff_data%0d", i),  writeBackData, ff_data[i]);
      check_val($sformatf("ff_ready%0d", i), 32'(memReady), 32'(ff_rdy[i]));
      check_val($sformatf("ff_hold%0d", i),  32'(holdAlu), 32'(ff_hold[i]));
    end
    aluValid = 0; memValid = 0;

    // Register 0 and scoreboard corner
    aluValid = 1; aluRd = 0; aluData = 32'hFFFFFFFF;
    issueValid = 1; issueRd = 0;
    tick();
    check_val("r0_alu_rd",   32'(rdOut), 0);
    check_val("r0_alu_data", writeBackData, 0);
    check_val("r0_no_pend",  pendingMask, 0);
    aluValid = 0; issueRd = 7;
    tick();
    check_val("sb_set7", pendingMask, 32'h0000_0080);
    issueValid = 0;
    memValid = 1; memRd = 7; memData = 32'h77;
    tick();
    memValid = 0;
    issueValid = 1; issueRd = 7;
    tick();
    check_val("sb_pop_rd",   32'(rdOut), 7);
    check_val("sb_pop_data", writeBackData, 32'h77);
    check_val("sb_set_wins", pendingMask, 32'h0000_0080);
    issueValid = 0;
    memValid = 1; memRd = 0; memData = 32'h55;
    tick();
    memValid = 0;
    tick();
    check_val("r0_ld_rd",   32'(rdOut), 0);
    check_val("r0_ld_data", writeBackData, 0);

    // Mid-cycle reset with two loads queued behind ALU traffic
    aluValid = 1; aluRd = 1; aluData = 32'h11;
    issueValid = 1; issueRd = 20;
    memValid = 1; memRd = 21; memData = 32'hE1;
    tick();
    issueValid = 0;
    memRd = 22; memData = 32'hE2;
    tick();
    check_val("mr_pre_rd",   32'(rdOut), 1);
    check_val("mr_pre_pend", pendingMask, 32'h0010_0080);
    #2 resetN = 1'b0;
    #1;
    check_val("mr_rd",      32'(rdOut), 0);
    check_val("mr_data",    writeBackData, 0);
    check_val("mr_pending", pendingMask, 0);
    check_val("mr_ready",   32'(memReady), 1);
    check_val("mr_hold",    32'(holdAlu), 0);
    aluValid = 0; memValid = 0;
    @(negedge clock);
    resetN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check_val($sformatf("mr_drain_rd%0d", i),   32'(rdOut), 0);
      check_val($sformatf("mr_drain_data%0d", i), writeBackData, 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/writeback_sequencer.md
Name: writeback_sequencer

Overview:
- Write-side driver for the register file's single write port, which writes unconditionally on every falling clock edge.
- Merges single-cycle ALU results with variable-latency memory-load results.
- Buffers loads in a small FIFO and presents exactly one register write per cycle as rdOut and writeBackData.
- Keeps a pending-load scoreboard for the hazard/stall logic.

Parameters:
- DEPTH, 4, load-result FIFO entries (power of two, 2..16).
- STARVE_LIMIT, 3, consecutive cycles a non-empty FIFO head may lose to the ALU before the ALU is held.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetN  in  1  asynchronous active-low reset.
- aluValid  in  1  ALU result present this cycle.
- aluRd  in  5  ALU destination register.
- aluData  in  32  ALU result.
- holdAlu  out  1  registered; ALU result not accepted this cycle, upstream holds aluValid/aluRd/aluData stable.
- memValid  in  1  load result present.
- memRd  in  5  load destination.
- memData  in  32  load data.
- memReady  out  1  FIFO can accept; a push occurs when memValid and memReady.
- issueValid  in  1  load issued this cycle.
- issueRd  in  5  destination of the issued load.
- rdOut  out  5  register-file write address.
- writeBackData  out  32  register-file write data.
- pendingMask  out  32  bit r set means a load to register r is outstanding.

Behaviour:
- Reset (async assert, sync deassert on clock):
  - rdOut=0, writeBackData=0, holdAlu=0, pendingMask=0, memReady=1.
  - FIFO empty; starvation counter=0.
  - Reset mid-operation discards FIFO contents and pending bits.
- Idle write: when nothing is selected, drive rdOut=0 and writeBackData=0. Register 0 is thereby rewritten with zero every idle cycle.
- Register 0 requests: any selected result with rd=0 is emitted as rdOut=0 with writeBackData=0; its data is discarded.
- Output register: rdOut/writeBackData are registered and update on the rising edge after selection. The register file commits them on the following falling edge.
- Selection each cycle, in priority order:
  - aluValid && !holdAlu: ALU result taken.
  - else if FIFO non-empty: head is popped.
  - else: idle write.
- Latency: ALU result visible one cycle after acceptance. A load visible no earlier than two cycles after its push; there is no FIFO bypass.
- FIFO:
  - count is 0..DEPTH; pointers are log2(DEPTH) bits wide and wrap modulo DEPTH.
  - memReady = (count != DEPTH), computed from registered count. When full, memReady=0 even in a cycle where a pop occurs.
  - Simultaneous push and pop: count unchanged.
  - memValid while !memReady: ignored; upstream holds the data.
- Starvation:
  - The counter increments each cycle the FIFO is non-empty and an ALU result is taken.
  - It clears on any pop or when the FIFO is empty.
  - When the counter reaches STARVE_LIMIT, holdAlu=1 for exactly the next cycle; the FIFO head pops in that cycle and the counter clears.
  - holdAlu never asserts in two consecutive cycles.
- Scoreboard:
  - issueValid with issueRd!=0 sets pendingMask[issueRd].
  - A popped FIFO entry clears pendingMask[rd] in the same edge its write is registered.
  - Set and clear of the same bit in the same cycle: set wins.
  - Register 0 is never set.

Decomposition:
- Shared package:
  - REG_ADDR_W=5, DATA_W=32, NUM_REGS=32 constants.
  - A wb_entry typedef holding rd and data.
- One sub-module, wb_fifo: parameterised DEPTH, push/pop/full/empty/count, head data combinational.
- Arbitration, starvation counter and scoreboard live in the top.

Test Plan:
- Reset: pulse resetN low mid-cycle with 2 FIFO entries queued -> outputs are immediately 0, pendingMask=0, memReady=1; the queued entries never appear on rdOut.
- ALU write: aluValid, aluRd=5, aluData=0xDEADBEEF -> next cycle rdOut=5, writeBackData=0xDEADBEEF; the cycle after that, rdOut=0, data=0.
- Load path: issueValid rd=9 -> pendingMask[9]=1. memValid rd=9 data=0x12345678 with no ALU traffic -> rdOut=9 two cycles after the push; pendingMask[9] clears at the same edge.
- Collision and starvation, STARVE_LIMIT=3: one load queued, aluValid held high continuously -> three ALU writes, then holdAlu=1 for one cycle with the load written, then the held ALU result is written next.
- FIFO full: DEPTH=4 pushes with the ALU saturating -> memReady=0 after the 4th push; a 5th memValid is not accepted. After a pop, memReady returns to 1; all 4 loads are written in order.
- Register 0 and scoreboard corner: ALU rd=0 data=0xFFFFFFFF -> writeBackData=0. issueValid rd=7 in the same cycle as load rd=7 is popped -> pendingMask[7] stays 1.
